// File: rtl/ram_arb_pkg.sv
// ============================================================================
//  Module   : ram_arb_pkg
//  Purpose  : Shared constants for the two-requester data RAM arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_arb_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MERGE = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    localparam logic [3:0] BE_FULL = 4'hF;
    localparam logic [3:0] BE_NONE = 4'h0;

endpackage

`default_nettype wire

// File: rtl/mem_byte_merge.sv
// ============================================================================
//  Module   : mem_byte_merge
//  Purpose  : Per-lane select between the stored word and new store data.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_byte_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] new_word,
    input  logic [3:0]  be,
    output logic [31:0] merged
);

    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_lane
            assign merged[8*k +: 8] = be[k] ? new_word[8*k +: 8] : old_word[8*k +: 8];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
//  Module   : ram_arbiter
//  Purpose  : Round-robin share of a single-port RAM between fetch and LSU,
//             with read-modify-write for partial-strobe stores.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 14,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_valid,
    input  logic [ADDR_WIDTH-1:0]     i_addr,
    output logic                      i_ready,
    output logic                      i_rsp_valid,
    output logic [DATA_WIDTH-1:0]     i_rdata,
    input  logic                      d_valid,
    input  logic                      d_we,
    input  logic [ADDR_WIDTH-1:0]     d_addr,
    input  logic [DATA_WIDTH-1:0]     d_wdata,
    input  logic [3:0]                d_be,
    output logic                      d_ready,
    output logic                      d_rsp_valid,
    output logic [DATA_WIDTH-1:0]     d_rdata,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]     ram_wdata,
    output logic                      ram_we,
    output logic                      ram_re,
    input  logic [DATA_WIDTH-1:0]     ram_rdata
);

    import ram_arb_pkg::*;

    logic [1:0]                r_state;
    logic                      r_last_grant;
    logic                      r_grant;
    logic [RAM_ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [3:0]                r_be;

    logic                      w_idle;
    logic                      w_merge;
    logic                      w_done;
    logic                      w_gnt_i;
    logic                      w_gnt_d;
    logic                      w_d_full;
    logic                      w_d_none;
    logic                      w_d_partial;
    logic [RAM_ADDR_WIDTH-1:0] w_i_waddr;
    logic [RAM_ADDR_WIDTH-1:0] w_d_waddr;
    logic [DATA_WIDTH-1:0]     w_merged;
    logic                      w_unused_addr_bits;

    assign w_i_waddr = i_addr[RAM_ADDR_WIDTH+1:2];
    assign w_d_waddr = d_addr[RAM_ADDR_WIDTH+1:2];

    // Upper address bits alias by design; byte offset is ignored.
    assign w_unused_addr_bits = ^{i_addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH+2], i_addr[1:0],
                                  d_addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH+2], d_addr[1:0]};

    assign w_idle  = rst_n && (r_state == IDLE);
    assign w_merge = rst_n && (r_state == MERGE);
    assign w_done  = rst_n && (r_state == DONE);

    // On a tie the requester that was not served last wins.
    assign w_gnt_i = w_idle && i_valid && (!d_valid || (r_last_grant == REQ_D));
    assign w_gnt_d = w_idle && d_valid && !w_gnt_i;

    assign w_d_full    = d_we && (d_be == BE_FULL);
    assign w_d_none    = d_we && (d_be == BE_NONE);
    assign w_d_partial = d_we && !w_d_full && !w_d_none;

    assign i_ready = w_gnt_i;
    assign d_ready = w_gnt_d;

    assign ram_re = w_gnt_i || (w_gnt_d && (!d_we || w_d_partial));
    assign ram_we = (w_gnt_d && w_d_full) || w_merge;

    assign i_rsp_valid = w_done && (r_grant == REQ_I);
    assign d_rsp_valid = w_done && (r_grant == REQ_D);
    assign i_rdata     = ram_rdata;
    assign d_rdata     = ram_rdata;

    mem_byte_merge u_merge (
        .old_word (ram_rdata),
        .new_word (r_wdata),
        .be       (r_be),
        .merged   (w_merged)
    );

    // Address and data come straight from the winning request so the RAM
    // samples them at the accept edge; otherwise the latched copy is held.
    always_comb begin
        ram_addr = r_addr;
        if (w_gnt_i) begin
            ram_addr = w_i_waddr;
        end else if (w_gnt_d) begin
            ram_addr = w_d_waddr;
        end
    end

    always_comb begin
        ram_wdata = r_wdata;
        if (w_merge) begin
            ram_wdata = w_merged;
        end else if (w_gnt_d) begin
            ram_wdata = d_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= REQ_D;
            r_grant      <= REQ_I;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_be         <= BE_NONE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt_i) begin
                        r_grant      <= REQ_I;
                        r_last_grant <= REQ_I;
                        r_addr       <= w_i_waddr;
                        r_state      <= DONE;
                    end else if (w_gnt_d) begin
                        r_grant      <= REQ_D;
                        r_last_grant <= REQ_D;
                        r_addr       <= w_d_waddr;
                        r_wdata      <= d_wdata;
                        r_be         <= d_be;
                        r_state      <= w_d_partial ? MERGE : DONE;
                    end
                end
                MERGE:   r_state <= DONE;
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port, word-wide data RAM between two requesters: instruction fetch (read-only) and the load/store unit (read/write with byte strobes).
- The RAM registers its read data one cycle after `ram_re` and has no byte enables. This block sequences reads and full-word writes, and performs read-modify-write for sub-word stores.
- Sits between the core's IF/MEM stages and the RAM instance.

Parameters:
- ADDR_WIDTH, 32, requester byte-address width.
- RAM_ADDR_WIDTH, 14, RAM word-address width; RAM depth is 2^RAM_ADDR_WIDTH words.
- DATA_WIDTH, 32, data width; fixed at 32 because strobes are 4 bits.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- i_valid  in  1  fetch request valid.
- i_addr  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored.
- i_ready  out  1  fetch request accepted this cycle.
- i_rsp_valid  out  1  fetch response pulse.
- i_rdata  out  DATA_WIDTH  fetch read word; valid when i_rsp_valid is high.
- d_valid  in  1  LSU request valid.
- d_we  in  1  LSU write (1) or read (0).
- d_addr  in  ADDR_WIDTH  LSU byte address; bits [1:0] ignored.
- d_wdata  in  DATA_WIDTH  LSU write data, lane-aligned.
- d_be  in  4  LSU byte strobes; bit k enables byte lane k.
- d_ready  out  1  LSU request accepted this cycle.
- d_rsp_valid  out  1  LSU completion pulse, for reads and writes.
- d_rdata  out  DATA_WIDTH  LSU read word; valid when d_rsp_valid is high.
- ram_addr  out  RAM_ADDR_WIDTH  word address to the RAM.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_re  out  1  RAM read enable.
- ram_rdata  in  DATA_WIDTH  RAM registered read data.

Behaviour:
- Reset (rst_n low at posedge):
  - State goes to IDLE and any in-flight transaction is dropped; no response is ever issued for it.
  - last_grant is set to D, so the first tie goes to fetch.
  - While rst_n is low, these outputs are forced to 0: i_ready, d_ready, i_rsp_valid, d_rsp_valid, ram_we, ram_re.
  - Registered outputs reset to 0: ram_addr, ram_wdata, latched address/data/strobes.
- Handshake:
  - A requester holds valid and all request fields stable until ready is high.
  - Ready is combinational and is asserted only in IDLE, to at most one requester per cycle.
  - Acceptance occurs when valid && ready at the clock edge.
- Arbitration:
  - Round-robin, two-way.
  - Only one valid → that requester is granted.
  - Both valid → the requester not equal to last_grant is granted.
  - last_grant updates on every accept.
- Address mapping: ram_addr = addr[RAM_ADDR_WIDTH+1:2]. Upper bits are ignored, so addresses alias.
- FSM states: IDLE, MERGE, DONE.
  - IDLE with a read accepted (fetch, or LSU with d_we=0):
    - ram_re=1 in the accept cycle.
    - Go to DONE.
    - In DONE, rsp_valid=1 for the granted requester and rdata = ram_rdata.
    - Latency from accept to response is 1 cycle.
  - IDLE with an LSU write, d_be==4'hF:
    - ram_we=1 and ram_wdata=d_wdata in the accept cycle.
    - Go to DONE; d_rsp_valid=1 there.
  - IDLE with an LSU write, d_be==4'h0:
    - No RAM access.
    - Go to DONE; d_rsp_valid=1 there.
  - IDLE with an LSU write, any other d_be:
    - ram_re=1 in the accept cycle; latch address, wdata and be.
    - Go to MERGE.
    - In MERGE: ram_we=1 at the same ram_addr. For each lane k, ram_wdata lane = be[k] ? wdata lane : ram_rdata lane.
    - Go to DONE; d_rsp_valid=1 there.
  - DONE → IDLE unconditionally. No accept in DONE or MERGE.
- Throughput: 2 cycles per read or full-word write; 3 cycles per sub-word write.
- Response signals:
  - Response pulses are exactly 1 cycle.
  - The non-granted requester's rsp_valid stays 0.
  - rdata is don't-care when rsp_valid is low.
  - d_rdata is don't-care for write responses.
- ram_re and ram_we are never high in the same cycle.

Decomposition:
- Package ram_arb_pkg holds:
  - state encoding IDLE/MERGE/DONE;
  - requester id constants: REQ_I=0, REQ_D=1;
  - BE_FULL=4'hF, BE_NONE=4'h0.
- Sub-module mem_byte_merge, purely combinational:
  - inputs: old word, new word, be[3:0];
  - output: merged word;
  - instantiated once, used in MERGE.

Test Plan:
1. Fetch only: i_valid with i_addr=0x10 after the RAM is preloaded with word 4 = 0xDEADBEEF → i_ready in cycle 0, ram_re with ram_addr=4, i_rsp_valid in cycle 1 with i_rdata=0xDEADBEEF.
2. Simultaneous requests after reset: i_valid and d_valid high with reads at 0x0 and 0x4 → fetch granted first, LSU granted at the next IDLE; with both held valid, grants alternate I, D, I, D.
3. Sub-word store: word 2 = 0x11223344; LSU write addr=0x8, d_wdata=0x0000AA00, d_be=4'b0010 → ram_re, then MERGE ram_we with ram_wdata=0x1122AA44, then d_rsp_valid; readback returns 0x1122AA44.
4. Write strobe edge cases: d_be=4'hF with 0xCAFEF00D → single-cycle ram_we, readback 0xCAFEF00D. d_be=4'h0 → d_rsp_valid with no ram_we or ram_re asserted.
5. Reset mid-operation: assert rst_n=0 during MERGE → no ram_we, no d_rsp_valid, state is IDLE on release, and word contents are unchanged; the first tie after release is granted to fetch.
6. Address aliasing: with RAM_ADDR_WIDTH=14, d_addr=0x0001_0004 and 0x0000_0004 both map to ram_addr=1.
